// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk-cycle spacing between rising edges of a tick
// stream, publishes each period over a valid/ack handshake and tracks
// min/max period plus sticky overrun and timeout flags.
module tick_period_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ack,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             tick_d;
  logic             tick_edge;
  logic             capture;
  logic             timeout_hit;

  logic [CNT_W-1:0] period_nx, min_nx, max_nx, min_base, max_base;
  logic             valid_nx, overrun_nx, timeout_nx, overrun_base, timeout_base;

  assign tick_edge = tick_in & ~tick_d;

  // Next-state, counter and result-register update logic
  always_comb begin
    state_nx    = state;
    count_nx    = count;
    capture     = 1'b0;
    timeout_hit = 1'b0;

    if (!enable) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = ARMED;
          count_nx = '0;
        end
        ARMED: begin
          if (tick_edge) begin
            state_nx = MEASURE;
            count_nx = CNT_ONE;
          end
        end
        MEASURE: begin
          if (tick_edge) begin
            capture  = 1'b1;
            count_nx = CNT_ONE;
          end else if (count == CNT_MAX) begin
            // saturated without an edge: drop the stream and re-arm
            timeout_hit = 1'b1;
            count_nx    = '0;
            state_nx    = ARMED;
          end else begin
            count_nx = count + CNT_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end

    // clear takes effect before a coincident capture
    min_base     = clear ? CNT_MAX : min_period;
    max_base     = clear ? '0      : max_period;
    overrun_base = clear ? 1'b0    : overrun;
    timeout_base = clear ? 1'b0    : timeout;

    period_nx  = period;
    valid_nx   = period_valid;
    min_nx     = min_base;
    max_nx     = max_base;
    overrun_nx = overrun_base;
    timeout_nx = timeout_base | timeout_hit;

    if (capture) begin
      period_nx  = count;
      valid_nx   = 1'b1;
      min_nx     = (count < min_base) ? count : min_base;
      max_nx     = (count > max_base) ? count : max_base;
      overrun_nx = overrun_base | (period_valid & ~period_ack);
    end else if (period_valid && period_ack) begin
      valid_nx = 1'b0;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      tick_d       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      min_period   <= CNT_MAX;
      max_period   <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      tick_d       <= tick_in;
      period       <= period_nx;
      period_valid <= valid_nx;
      min_period   <= min_nx;
      max_period   <= max_nx;
      overrun      <= overrun_nx;
      timeout      <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed testbench for tick_period_meter (16-bit and 4-bit instances).
module tb_tick_period_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, clear = 1'b0, tick_in = 1'b0, period_ack = 1'b0;
  logic [15:0] period, min_period, max_period;
  logic        period_valid, overrun, timeout;

  logic        enable4 = 1'b0, clear4 = 1'b0, tick4 = 1'b0, ack4 = 1'b0;
  logic [3:0]  period4, min4, max4;
  logic        valid4, overrun4, timeout4;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tick_period_meter #(.CNT_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .tick_in(tick_in),
    .period(period), .period_valid(period_valid), .period_ack(period_ack),
    .min_period(min_period), .max_period(max_period),
    .overrun(overrun), .timeout(timeout)
  );

  tick_period_meter #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable4), .clear(clear4), .tick_in(tick4),
    .period(period4), .period_valid(valid4), .period_ack(ack4),
    .min_period(min4), .max_period(max4),
    .overrun(overrun4), .timeout(timeout4)
  );

  // advance n active edges, then settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
  endtask

  // next tick edge p cycles after the previous one
  task automatic gap(input int p);
    cyc(p - 1);
    pulse();
  endtask

  task automatic gap_ack(input int p);
    period_ack = 1'b1;
    cyc(1);
    period_ack = 1'b0;
    cyc(p - 2);
    pulse();
  endtask

  task automatic restart();
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    n_cmp++; if (period !== 16'd0) begin n_fail++; $display("FAIL reset_period got %0d want 0", period); end
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", period_valid); end
    n_cmp++; if (min_period !== 16'hFFFF) begin n_fail++; $display("FAIL reset_min got %h want ffff", min_period); end
    n_cmp++; if (max_period !== 16'd0) begin n_fail++; $display("FAIL reset_max got %0d want 0", max_period); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_divider();
    enable = 1'b1;
    cyc(1);
    pulse();
    for (int i = 0; i < 4; i++) begin
      gap_ack(1001);
      n_cmp++; if (period !== 16'd1001) begin n_fail++; $display("FAIL div_period[%0d] got %0d want 1001", i, period); end
      n_cmp++; if (period_valid !== 1'b1) begin n_fail++; $display("FAIL div_valid[%0d] got %b want 1", i, period_valid); end
    end
    n_cmp++; if (min_period !== 16'd1001) begin n_fail++; $display("FAIL div_min got %0d want 1001", min_period); end
    n_cmp++; if (max_period !== 16'd1001) begin n_fail++; $display("FAIL div_max got %0d want 1001", max_period); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL div_overrun got %b want 0", overrun); end
    period_ack = 1'b1;
    cyc(1);
    period_ack = 1'b0;
  endtask

  task automatic test_handshake();
    restart();
    pulse();
    gap(10);
    n_cmp++; if (period !== 16'd10) begin n_fail++; $display("FAIL hs_first_period got %0d want 10", period); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL hs_first_overrun got %b want 0", overrun); end
    gap(10);
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL hs_overrun got %b want 1", overrun); end
    n_cmp++; if (period !== 16'd10) begin n_fail++; $display("FAIL hs_overrun_period got %0d want 10", period); end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL hs_clear_overrun got %b want 0", overrun); end
    cyc(8);
    period_ack = 1'b1;
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    period_ack = 1'b0;
    n_cmp++; if (period_valid !== 1'b1) begin n_fail++; $display("FAIL hs_ack_capture_valid got %b want 1", period_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL hs_ack_capture_overrun got %b want 0", overrun); end
    n_cmp++; if (period !== 16'd10) begin n_fail++; $display("FAIL hs_ack_capture_period got %0d want 10", period); end
    n_cmp++; if (min_period !== 16'd10) begin n_fail++; $display("FAIL hs_min_after_clear got %0d want 10", min_period); end
    period_ack = 1'b1;
    cyc(1);
    period_ack = 1'b0;
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL hs_ack_clears got %b want 0", period_valid); end
  endtask

  task automatic test_minmax_clear();
    restart();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    pulse();
    gap(7);
    gap(3);
    gap(12);
    n_cmp++; if (period !== 16'd12) begin n_fail++; $display("FAIL mm_period got %0d want 12", period); end
    n_cmp++; if (min_period !== 16'd3) begin n_fail++; $display("FAIL mm_min got %0d want 3", min_period); end
    n_cmp++; if (max_period !== 16'd12) begin n_fail++; $display("FAIL mm_max got %0d want 12", max_period); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL mm_overrun got %b want 1", overrun); end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    n_cmp++; if (min_period !== 16'hFFFF) begin n_fail++; $display("FAIL clr_min got %h want ffff", min_period); end
    n_cmp++; if (max_period !== 16'd0) begin n_fail++; $display("FAIL clr_max got %0d want 0", max_period); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_overrun got %b want 0", overrun); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL clr_timeout got %b want 0", timeout); end
  endtask

  task automatic test_timeout();
    tick4 = 1'b1;
    cyc(1);
    tick4 = 1'b0;
    cyc(14);
    n_cmp++; if (timeout4 !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", timeout4); end
    cyc(1);
    n_cmp++; if (timeout4 !== 1'b1) begin n_fail++; $display("FAIL to_set got %b want 1", timeout4); end
    n_cmp++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL to_no_capture got %b want 0", valid4); end
    cyc(2);
    tick4 = 1'b1;
    cyc(1);
    tick4 = 1'b0;
    n_cmp++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL to_rearm_only got %b want 0", valid4); end
    cyc(4);
    tick4 = 1'b1;
    cyc(1);
    tick4 = 1'b0;
    n_cmp++; if (period4 !== 4'd5) begin n_fail++; $display("FAIL to_period got %0d want 5", period4); end
    n_cmp++; if (valid4 !== 1'b1) begin n_fail++; $display("FAIL to_valid got %b want 1", valid4); end
  endtask

  task automatic test_enable_held();
    period_ack = 1'b1;
    cyc(1);
    period_ack = 1'b0;
    restart();
    pulse();
    cyc(4);
    enable = 1'b0;
    cyc(2);
    pulse();
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL en_no_capture got %b want 0", period_valid); end
    enable = 1'b1;
    cyc(1);
    pulse();
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL en_arm_only got %b want 0", period_valid); end
    gap(6);
    n_cmp++; if (period !== 16'd6) begin n_fail++; $display("FAIL en_period got %0d want 6", period); end
    // minimum period 2 on the rising edge, then a held-high level
    period_ack = 1'b1;
    cyc(1);
    tick_in = 1'b1;
    cyc(4);
    tick_in = 1'b0;
    period_ack = 1'b0;
    n_cmp++; if (period !== 16'd2) begin n_fail++; $display("FAIL held_min_period got %0d want 2", period); end
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL held_single_edge got %b want 0", period_valid); end
    cyc(3);
    pulse();
    n_cmp++; if (period !== 16'd7) begin n_fail++; $display("FAIL held_period got %0d want 7", period); end
    n_cmp++; if (min_period !== 16'd2) begin n_fail++; $display("FAIL held_min got %0d want 2", min_period); end
    n_cmp++; if (max_period !== 16'd7) begin n_fail++; $display("FAIL held_max got %0d want 7", max_period); end
  endtask

  task automatic test_async_reset();
    pulse();
    cyc(3);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (period !== 16'd0) begin n_fail++; $display("FAIL ar_period got %0d want 0", period); end
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b want 0", period_valid); end
    n_cmp++; if (min_period !== 16'hFFFF) begin n_fail++; $display("FAIL ar_min got %h want ffff", min_period); end
    n_cmp++; if (max_period !== 16'd0) begin n_fail++; $display("FAIL ar_max got %0d want 0", max_period); end
    n_cmp++; if (timeout4 !== 1'b0) begin n_fail++; $display("FAIL ar_timeout got %b want 0", timeout4); end
    #1;
    reset = 1'b0;
    cyc(1);
    pulse();
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL ar_arm_only got %b want 0", period_valid); end
    gap(4);
    n_cmp++; if (period !== 16'd4) begin n_fail++; $display("FAIL ar_period_after got %0d want 4", period); end
  endtask

  initial begin
    enable4 = 1'b1;
    test_reset();
    test_divider();
    test_handshake();
    test_minmax_clear();
    test_timeout();
    test_enable_held();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
